pulse_to_level: RTL and testbench

PULSE_TO_LEVEL -- requirements
Module: pulse_to_level

---
 rtl/pulse_to_level.sv | 167 ++++++++++++++++
 tb/tb_pulse_to_level.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_to_level.sv
// rtl/pulse_to_level.sv - stretches input event pulses into fixed-width output windows with a bounded event queue
//
// Each accepted event produces one HOLD_CYCLES-long high window on dout. Consecutive
// windows are separated by at least GAP_CYCLES low clocks. Events that arrive while a
// window or gap is running are counted (up to PEND_MAX). Events beyond that are dropped
// and flagged.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   pin       event input, one event per cycle sampled high
//   clr_ovf   synchronous clear of the sticky overflow flag
//   dout      stretched level output (registered)
//   busy      high while a window or gap is in progress (registered)
//   pend_cnt  number of queued events not yet output (registered)
//   overflow  sticky drop indicator (registered)

module pulse_to_level #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_MAX    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pin,
  input  logic       clr_ovf,
  output logic       dout,
  output logic       busy,
  output logic [3:0] pend_cnt,
  output logic       overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Counters are loaded with length-1 and the phase ends on the edge where they read 0.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam bit         HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [7:0] GAP_LOAD  = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [3:0] PEND_TOP  = 4'(PEND_MAX);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_hold;
  logic [7:0] w_hold_nxt;
  logic [7:0] r_gap;
  logic [7:0] w_gap_nxt;
  logic [3:0] r_pend;
  logic [3:0] w_pend_nxt;
  logic       r_ovf;
  logic       w_ovf_nxt;
  logic       r_dout;
  logic       r_busy;
  logic       w_win_end;
  logic       w_deq;
  logic       w_direct;
  logic       w_enq;
  logic       w_drop;

  always_comb begin
    w_next     = r_state;
    w_hold_nxt = r_hold;
    w_gap_nxt  = r_gap;
    w_win_end  = 1'b0;
    w_deq      = 1'b0;
    w_direct   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (pin) begin
          w_next     = S_HIGH;
          w_hold_nxt = HOLD_LOAD;
        end
      end
      S_HIGH: begin
        if (r_hold == 8'd0) begin
          if (HAS_GAP) begin
            w_next    = S_GAP;
            w_gap_nxt = GAP_LOAD;
          end else begin
            w_win_end = 1'b1;
          end
        end else begin
          w_hold_nxt = r_hold - 8'd1;
        end
      end
      S_GAP: begin
        if (r_gap == 8'd0) begin
          w_win_end = 1'b1;
        end else begin
          w_gap_nxt = r_gap - 8'd1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // End of a window/gap: start the next window from the queue, or from an event
    // arriving right now when the queue is empty (so pend_cnt never sits non-zero in IDLE).
    if (w_win_end) begin
      if (r_pend != 4'd0) begin
        w_next     = S_HIGH;
        w_hold_nxt = HOLD_LOAD;
        w_deq      = 1'b1;
      end else if (pin) begin
        w_next     = S_HIGH;
        w_hold_nxt = HOLD_LOAD;
        w_direct   = 1'b1;
      end else begin
        w_next = S_IDLE;
      end
    end
  end

  always_comb begin
    w_enq      = pin && (r_state != S_IDLE) && !w_direct;
    w_drop     = 1'b0;
    w_pend_nxt = r_pend;
    if (w_enq && !w_deq) begin
      if (r_pend < PEND_TOP) begin
        w_pend_nxt = r_pend + 4'd1;
      end else begin
        w_drop = 1'b1;
      end
    end else if (!w_enq && w_deq) begin
      w_pend_nxt = r_pend - 4'd1;
    end
    // A drop in the same cycle as a clear leaves the flag set.
    if (w_drop) begin
      w_ovf_nxt = 1'b1;
    end else if (clr_ovf) begin
      w_ovf_nxt = 1'b0;
    end else begin
      w_ovf_nxt = r_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hold  <= 8'd0;
      r_gap   <= 8'd0;
      r_pend  <= 4'd0;
      r_ovf   <= 1'b0;
      r_dout  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hold  <= w_hold_nxt;
      r_gap   <= w_gap_nxt;
      r_pend  <= w_pend_nxt;
      r_ovf   <= w_ovf_nxt;
      r_dout  <= (w_next == S_HIGH);
      r_busy  <= (w_next != S_IDLE);
    end
  end

  assign dout     = r_dout;
  assign busy     = r_busy;
  assign pend_cnt = r_pend;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_pulse_to_level.sv
// tb/tb_pulse_to_level.sv - scoreboard bench for pulse_to_level
module tb_pulse_to_level;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pin;
  logic       clr_ovf;
  logic       dout;
  logic       busy;
  logic [3:0] pend_cnt;
  logic       overflow;

  logic       pin_b;
  logic       clr_b;
  logic       dout_b;
  logic       busy_b;
  logic [3:0] pend_b;
  logic       ovf_b;

  always #5 clk = ~clk;

  pulse_to_level #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .PEND_MAX(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .pin(pin), .clr_ovf(clr_ovf),
    .dout(dout), .busy(busy), .pend_cnt(pend_cnt), .overflow(overflow)
  );

  pulse_to_level #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .PEND_MAX(3)) u_dut_g0 (
    .clk(clk), .rst_n(rst_n), .pin(pin_b), .clr_ovf(clr_b),
    .dout(dout_b), .busy(busy_b), .pend_cnt(pend_b), .overflow(ovf_b)
  );

  typedef struct {
    int         cyc;
    logic [6:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic in_rng(int c, int lo, int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; pin = 1'b0; clr_ovf = 1'b0; pin_b = 1'b0; clr_b = 1'b0;
    #3;
    n_checks++;
    if ({dout, busy, pend_cnt, overflow} !== 7'd0) begin
      n_fail++; $display("FAIL reset_state got=%b exp=%b", {dout, busy, pend_cnt, overflow}, 7'd0);
    end
    n_checks++;
    if ({dout_b, busy_b, pend_b, ovf_b} !== 7'd0) begin
      n_fail++; $display("FAIL reset_state_g0 got=%b exp=%b", {dout_b, busy_b, pend_b, ovf_b}, 7'd0);
    end
    @(posedge clk); @(posedge clk);
    // event at the very first edge after release is accepted
    @(negedge clk); rst_n = 1'b1; pin = 1'b1;
    for (int c = 2; c <= 9; c++)
      sb.push_back('{c, {in_rng(c, 2, 5), in_rng(c, 2, 7), 4'd0, 1'b0}});
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); n_checks++;
        if ({dout, busy, pend_cnt, overflow} !== e.val) begin
          n_fail++; $display("FAIL release_event cyc=%0d got=%b exp=%b", k, {dout, busy, pend_cnt, overflow}, e.val);
        end
      end
      pin = 1'b0;
    end
  endtask

  task automatic test_single();
    for (int c = 1; c <= 20; c++)
      sb.push_back('{c, {in_rng(c, 11, 14), in_rng(c, 11, 16), 4'd0, 1'b0}});
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); n_checks++;
        if ({dout, busy, pend_cnt, overflow} !== e.val) begin
          n_fail++; $display("FAIL single cyc=%0d got=%b exp=%b", k, {dout, busy, pend_cnt, overflow}, e.val);
        end
      end
      pin = (k == 10);
    end
  endtask

  task automatic test_two_pulses();
    for (int c = 1; c <= 24; c++)
      sb.push_back('{c, {in_rng(c, 11, 14) | in_rng(c, 17, 20), in_rng(c, 11, 22),
                         in_rng(c, 13, 16) ? 4'd1 : 4'd0, 1'b0}});
    @(posedge clk);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); n_checks++;
        if ({dout, busy, pend_cnt, overflow} !== e.val) begin
          n_fail++; $display("FAIL two_pulses cyc=%0d got=%b exp=%b", k, {dout, busy, pend_cnt, overflow}, e.val);
        end
      end
      pin = (k == 10) || (k == 12);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] p;
    for (int c = 1; c <= 36; c++) begin
      if (c <= 11)      p = 4'd0;
      else if (c == 12) p = 4'd1;
      else if (c == 13) p = 4'd2;
      else if (c <= 16) p = 4'd3;
      else if (c <= 22) p = 4'd2;
      else if (c <= 28) p = 4'd1;
      else              p = 4'd0;
      sb.push_back('{c, {in_rng(c, 11, 14) | in_rng(c, 17, 20) | in_rng(c, 23, 26) | in_rng(c, 29, 32),
                         in_rng(c, 11, 34), p, in_rng(c, 15, 30)}});
    end
    @(posedge clk);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); n_checks++;
        if ({dout, busy, pend_cnt, overflow} !== e.val) begin
          n_fail++; $display("FAIL overflow cyc=%0d got=%b exp=%b", k, {dout, busy, pend_cnt, overflow}, e.val);
        end
      end
      pin     = (k >= 10) && (k <= 14);
      clr_ovf = (k == 30);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 1; c <= 36; c++)
      sb.push_back('{c, {in_rng(c, 11, 14) | in_rng(c, 17, 20) | in_rng(c, 23, 26) | in_rng(c, 29, 32),
                         in_rng(c, 11, 34),
                         (in_rng(c, 13, 16) | in_rng(c, 19, 28)) ? 4'd1 : 4'd0, 1'b0}});
    @(posedge clk);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); n_checks++;
        if ({dout, busy, pend_cnt, overflow} !== e.val) begin
          n_fail++; $display("FAIL back_to_back cyc=%0d got=%b exp=%b", k, {dout, busy, pend_cnt, overflow}, e.val);
        end
      end
      pin = (k == 10) || (k == 12) || (k == 18) || (k == 22);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 1; c <= 13; c++)
      sb.push_back('{c, {in_rng(c, 11, 13), in_rng(c, 11, 13),
                         (c == 12) ? 4'd1 : ((c == 13) ? 4'd2 : 4'd0), 1'b0}});
    @(posedge clk);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); n_checks++;
        if ({dout, busy, pend_cnt, overflow} !== e.val) begin
          n_fail++; $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", k, {dout, busy, pend_cnt, overflow}, e.val);
        end
      end
      pin = (k >= 10) && (k <= 12);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dout, busy, pend_cnt} !== 6'd0) begin
      n_fail++; $display("FAIL reset_mid_async got=%b exp=%b", {dout, busy, pend_cnt}, 6'd0);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) sb.push_back('{c, 7'd0});
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); n_checks++;
        if ({dout, busy, pend_cnt, overflow} !== e.val) begin
          n_fail++; $display("FAIL reset_mid_post cyc=%0d got=%b exp=%b", k, {dout, busy, pend_cnt, overflow}, e.val);
        end
      end
    end
  endtask

  task automatic test_gap_zero();
    for (int c = 1; c <= 21; c++)
      sb.push_back('{c, {in_rng(c, 11, 18), in_rng(c, 11, 18),
                         in_rng(c, 12, 14) ? 4'd1 : 4'd0, 1'b0}});
    @(posedge clk);
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); n_checks++;
        if ({dout_b, busy_b, pend_b, ovf_b} !== e.val) begin
          n_fail++; $display("FAIL gap_zero cyc=%0d got=%b exp=%b", k, {dout_b, busy_b, pend_b, ovf_b}, e.val);
        end
      end
      pin_b = (k == 10) || (k == 11);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_pulses();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_gap_zero();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain got=%0d exp=%0d", sb.size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
